// File: rtl/escaneo_display.sv
// Scan scheduler for a multiplexed 7-segment display: one digit per slot, with dark dead-time at the start of each slot.
// Registered outputs; the digit's data, enable and decimal point are captured when its slot lights and held until the slot ends.
module escaneo_display #(
  parameter int DIV_COUNT    = 9999,
  parameter int BLANK_CYCLES = 100,
  parameter int N_DIGITS     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*N_DIGITS-1:0]   digit_data,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int CW = $clog2(DIV_COUNT + 1);
  localparam int IW = $clog2(N_DIGITS);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV_COUNT);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [BW-1:0] bcnt;

  logic          tick;
  logic [IW-1:0] idx_inc;
  logic          enter_show;
  logic [IW-1:0] entry_idx;
  logic [3:0]    entry_nib;

  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick      = (cnt == CNT_LAST);
  assign idx_inc   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  assign entry_nib = digit_data[4*entry_idx +: 4];

  // With zero dead-time a slot boundary goes straight into the next SHOW.
  always_comb begin
    enter_show = 1'b0;
    entry_idx  = idx;
    if (enable) begin
      unique case (state)
        IDLE: begin
          if (tick && BLANK_CYCLES == 0) begin
            enter_show = 1'b1;
            entry_idx  = '0;
          end
        end
        BLANK: begin
          if (bcnt == BLANK_LAST) enter_show = 1'b1;
        end
        SHOW: begin
          if (tick && BLANK_CYCLES == 0) begin
            enter_show = 1'b1;
            entry_idx  = idx_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      bcnt       <= '0;
      an         <= '1;
      seg        <= 7'h7F;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
        bcnt  <= '0;
        an    <= '1;
        seg   <= 7'h7F;
        dp_n  <= 1'b1;
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (enter_show) begin
          state      <= SHOW;
          idx        <= entry_idx;
          an         <= digit_en[entry_idx] ? ~(N_DIGITS'(1) << entry_idx) : '1;
          seg        <= decode(entry_nib);
          dp_n       <= ~dp_in[entry_idx];
          frame_done <= (entry_idx == IDX_LAST);
        end else begin
          unique case (state)
            IDLE: begin
              if (tick) begin
                state <= BLANK;
                idx   <= '0;
                bcnt  <= '0;
              end
            end
            BLANK: bcnt <= bcnt + 1'b1;
            SHOW: begin
              if (tick) begin
                state <= BLANK;
                idx   <= idx_inc;
                bcnt  <= '0;
                an    <= '1;
                seg   <= 7'h7F;
                dp_n  <= 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
